// File: rtl/sumador_secuencial.sv
// sumador_secuencial: NBYTES*8-bit adder built from one shared 8-bit
// ripple-carry slice, one byte per clock (LSB first) with the carry kept
// in a register between bytes. start/ready/busy/done handshake.
// Optional feature: define SUM_SEQ_OVF_EN to add the signed-overflow
// output ovf.

// One 8-bit ripple-carry slice built from a chain of full adders.
module sumador_secuencial_slice #(
  parameter int PwrC = 0
) (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c_s;

  // Annotation hook for power tooling; it adds no logic.
  if (PwrC != 0) begin : g_pwr_annot
  end

  // Ripple the carry through eight full-adder cells.
  always_comb begin
    c_s    = 9'd0;
    sum    = 8'd0;
    c_s[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i + 1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c_s[8];

endmodule

module sumador_secuencial #(
  parameter int NBYTES = 4,
  parameter int PwrC   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  ci,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   s,
  output logic                  co
`ifdef SUM_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int         W        = 8 * NBYTES;
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   s_q, s_d;
  logic [2:0]     idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           co_q, co_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
`ifdef SUM_SEQ_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic [7:0]     slice_a_s;
  logic [7:0]     slice_b_s;
  logic [7:0]     slice_sum_s;
  logic           slice_co_s;

  // Select the operand bytes addressed by the current byte index.
  always_comb begin
    slice_a_s = 8'd0;
    slice_b_s = 8'd0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx_q == 3'(k)) begin
        slice_a_s = a_q[8*k +: 8];
        slice_b_s = b_q[8*k +: 8];
      end else begin
        slice_a_s = slice_a_s;
        slice_b_s = slice_b_s;
      end
    end
  end

  sumador_secuencial_slice #(
    .PwrC (PwrC)
  ) u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_q),
    .sum  (slice_sum_s),
    .cout (slice_co_s)
  );

  // Next-state, datapath update and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    co_d    = co_q;
`ifdef SUM_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE also accepts, which gives back-to-back operation.
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          carry_d = ci;
          idx_d   = 3'd0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx_q == 3'(k)) begin
            s_d[8*k +: 8] = slice_sum_s;
          end else begin
            s_d[8*k +: 8] = s_q[8*k +: 8];
          end
        end
        carry_d = slice_co_s;
        if (idx_q == LAST_IDX) begin
          // Index holds at the top byte; it is cleared on the next accept.
          co_d    = slice_co_s;
`ifdef SUM_SEQ_OVF_EN
          // Carry into bit 7 XOR carry out equals: operands agree in sign
          // and the sum sign differs.
          ovf_d   = (slice_a_s[7] == slice_b_s[7]) && (slice_sum_s[7] != slice_a_s[7]);
`endif
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d != ST_ADD);
    busy_d  = (state_d == ST_ADD);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= 3'd0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUM_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUM_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign co    = co_q;
`ifdef SUM_SEQ_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_secuencial.sv
// Self-checking bench for sumador_secuencial (NBYTES=4): directed table,
// handshake corner sequences and randomized operations against a
// plain-arithmetic reference.
module tb_sumador_secuencial;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ci;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        co;
`ifdef SUM_SEQ_OVF_EN
  logic        ovf;
`endif

  int tests;
  int fails;

  sumador_secuencial #(
    .NBYTES (4),
    .PwrC   (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .ci    (ci),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
`ifdef SUM_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic [31:0] exp_s;
    logic        exp_co;
    logic        exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation; return result, accept-to-done latency, busy cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input bit scramble,
                        output logic [31:0] rs, output logic rco, output logic rovf,
                        output int lat, output int nbusy);
    @(negedge clk);
    op_a = a; op_b = b; ci = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    if (scramble) begin
      op_a = $urandom; op_b = $urandom; ci = 1'($urandom_range(1, 0));
    end
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    rs  = s;
    rco = co;
`ifdef SUM_SEQ_OVF_EN
    rovf = ovf;
`else
    rovf = 1'b0;
`endif
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] rs;
    logic        rco;
    logic        rovf;
    int          lat;
    int          nbusy;
    int          ndone;
    logic [32:0] ref_sum;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        ref_ovf;

    tests = 0;
    fails = 0;
    reset = 1'b1; start = 1'b0; op_a = 32'd0; op_b = 32'd0; ci = 1'b0;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_s",     64'(s),     64'd0);
    check("rst_co",    64'(co),    64'd0);
`ifdef SUM_SEQ_OVF_EN
    check("rst_ovf",   64'(ovf),   64'd0);
`endif
    reset = 1'b0;

    // Directed table; operands scrambled while busy must not matter
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, rs, rco, rovf, lat, nbusy);
      check($sformatf("tbl%0d_lat", i),  64'(lat),   64'd5);
      check($sformatf("tbl%0d_busy", i), 64'(nbusy), 64'd4);
      check($sformatf("tbl%0d_s", i),    64'(rs),    64'(vecs[i].exp_s));
      check($sformatf("tbl%0d_co", i),   64'(rco),   64'(vecs[i].exp_co));
`ifdef SUM_SEQ_OVF_EN
      check($sformatf("tbl%0d_ovf", i),  64'(rovf),  64'(vecs[i].exp_ovf));
`endif
      @(negedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d_hold_s", i), 64'(s), 64'(vecs[i].exp_s));
      check($sformatf("tbl%0d_idle_ready", i), 64'(ready), 64'd1);
    end

    // start while busy is ignored and not queued
    @(negedge clk);
    op_a = 32'h12345678; op_b = 32'h11111111; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a = 32'hDEADBEEF; op_b = 32'h01010101; start = 1'b1;
    ndone = 0;
    for (int i = 3; i < 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        ndone++;
        check("ign_done_cycle", 64'(i), 64'd5);
        check("ign_s", 64'(s), 64'h23456789);
      end
    end
    check("ign_done_count", 64'(ndone), 64'd1);

    // start held high: back-to-back results every 5 cycles, no idle cycle
    @(negedge clk);
    op_a = 32'h00010001; op_b = 32'h00010001; ci = 1'b0; start = 1'b1;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("b2b_done%0d", i), 64'(done), 64'((i % 5) == 0));
      check($sformatf("b2b_busy%0d", i), 64'(busy), 64'((i % 5) != 0));
      if (done) begin
        ndone++;
        check($sformatf("b2b_s%0d", i), 64'(s), 64'h00020002);
      end
    end
    start = 1'b0;
    check("b2b_count", 64'(ndone), 64'd4);
    repeat (6) @(negedge clk);

    // Reset two cycles into an ADD
    op_a = 32'hFFFFFFFF; op_b = 32'h00000001; ci = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_s",     64'(s),     64'd0);
    check("mid_rst_co",    64'(co),    64'd0);
    check("mid_rst_busy",  64'(busy),  64'd0);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_done",  64'(done),  64'd0);
    reset = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_rst_no_done", 64'(ndone), 64'd0);
    run_op(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, rs, rco, rovf, lat, nbusy);
    check("post_rst_lat", 64'(lat), 64'd5);
    check("post_rst_s",   64'(rs),  64'h00010001);
    check("post_rst_co",  64'(rco), 64'd0);

    // Reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_s",    64'(s),    64'd0);
    reset = 1'b0; start = 1'b0;

    // Randomized operations against plain 33-bit arithmetic
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      if (i == 0) begin ra = 32'hFFFFFFFF; rb = 32'hFFFFFFFF; end
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      ref_ovf = (ra[31] == rb[31]) && (ref_sum[31] != ra[31]);
      run_op(ra, rb, rc, 1'b1, rs, rco, rovf, lat, nbusy);
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'd5);
      check($sformatf("rnd%0d_s", i),   64'(rs),  64'(ref_sum[31:0]));
      check($sformatf("rnd%0d_co", i),  64'(rco), 64'(ref_sum[32]));
`ifdef SUM_SEQ_OVF_EN
      check($sformatf("rnd%0d_ovf", i), 64'(rovf), 64'(ref_ovf));
`else
      if (ref_ovf) tests = tests + 0;
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
